// File: rtl/twiddle_cmult_if.sv
// twiddle_cmult_if: sample/twiddle input stream and product output stream
interface twiddle_cmult_if #(
    parameter int DATA_BW = 16,
    parameter int TW_BW   = 17
);
    logic                      din_valid;
    logic signed [DATA_BW-1:0] din_r;
    logic signed [DATA_BW-1:0] din_i;
    logic signed [TW_BW-1:0]   tw_fac_r;
    logic signed [TW_BW-1:0]   tw_fac_i;
    logic                      cordic_rdy;
    logic                      dout_valid;
    logic signed [DATA_BW-1:0] dout_r;
    logic signed [DATA_BW-1:0] dout_i;
    logic                      dout_last;
    logic                      sat_flag;

    modport master (
        output din_valid, din_r, din_i, tw_fac_r, tw_fac_i, cordic_rdy,
        input  dout_valid, dout_r, dout_i, dout_last, sat_flag
    );

    modport slave (
        input  din_valid, din_r, din_i, tw_fac_r, tw_fac_i, cordic_rdy,
        output dout_valid, dout_r, dout_i, dout_last, sat_flag
    );
endinterface

// File: rtl/twiddle_cmult.sv
// twiddle_cmult: 3-stage complex multiply by twiddle with Q1.15 rounding, saturation and frame tracking
module twiddle_cmult #(
    parameter int DATA_BW    = 16,
    parameter int TW_BW      = 17,
    parameter int FFT_LENGTH = 16
) (
    input  logic           sys_clk,
    input  logic           sys_nrst,
    input  logic           sys_en,
    twiddle_cmult_if.slave bus
);
    localparam int PW = DATA_BW + TW_BW;
    localparam int CW = $clog2(FFT_LENGTH);
    localparam logic signed [PW-15:0] MAXV = (PW-14)'(2**(DATA_BW-1) - 1);
    localparam logic signed [PW-15:0] MINV = -(PW-14)'(2**(DATA_BW-1));

    logic signed [DATA_BW-1:0] ar, ai;
    logic signed [TW_BW-1:0]   tr, ti;
    logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]        re, im;
    logic signed [PW-15:0]     re_q, im_q;
    logic                      v1, v2, accept, re_ovf, im_ovf;
    logic [CW-1:0]             cnt;

    always_comb begin
        accept = sys_en & bus.din_valid & bus.cordic_rdy;
        re     = (PW+1)'(p_rr) - (PW+1)'(p_ii) + (PW+1)'(16384);
        im     = (PW+1)'(p_ri) + (PW+1)'(p_ir) + (PW+1)'(16384);
        // dropping the low 15 bits of (x + 2^14) is round-half-up
        re_q   = re[PW:15];
        im_q   = im[PW:15];
        re_ovf = re_q > MAXV || re_q < MINV;
        im_ovf = im_q > MAXV || im_q < MINV;
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            ar             <= '0;
            ai             <= '0;
            tr             <= '0;
            ti             <= '0;
            v1             <= 1'b0;
            p_rr           <= '0;
            p_ii           <= '0;
            p_ri           <= '0;
            p_ir           <= '0;
            v2             <= 1'b0;
            cnt            <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_r     <= '0;
            bus.dout_i     <= '0;
            bus.dout_last  <= 1'b0;
            bus.sat_flag   <= 1'b0;
        end else if (sys_en) begin
            ar             <= bus.din_r;
            ai             <= bus.din_i;
            tr             <= bus.tw_fac_r;
            ti             <= bus.tw_fac_i;
            v1             <= accept;
            p_rr           <= PW'(ar) * PW'(tr);
            p_ii           <= PW'(ai) * PW'(ti);
            p_ri           <= PW'(ar) * PW'(ti);
            p_ir           <= PW'(ai) * PW'(tr);
            v2             <= v1;
            bus.dout_valid <= v2;
            bus.dout_last  <= v2 && cnt == CW'(FFT_LENGTH - 1);
            bus.sat_flag   <= v2 && (re_ovf || im_ovf);
            if (v2) begin
                cnt        <= cnt + 1'b1;
                bus.dout_r <= re_ovf ? (re_q[PW-15] ? MINV[DATA_BW-1:0] : MAXV[DATA_BW-1:0]) : re_q[DATA_BW-1:0];
                bus.dout_i <= im_ovf ? (im_q[PW-15] ? MINV[DATA_BW-1:0] : MAXV[DATA_BW-1:0]) : im_q[DATA_BW-1:0];
            end
        end
    end
endmodule
